// File: rtl/mcp3008_responder.sv
// MCP3008-style SPI ADC responder: answers command frames with 10-bit channel data.
// Optional MCP3008_LSB_TAIL_EN appends the LSB-first tail (B1..B9) after B0.
module mcp3008_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ad_clk,
  input  logic        cs,
  input  logic        din,
  input  logic [79:0] ch_data,
  output logic        dout,
  output logic        dout_oe,
  output logic [2:0]  last_ch,
  output logic        last_sgl,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    CMD        = 3'd2,
    NULLB      = 3'd3,
    MSB        = 3'd4,
`ifdef MCP3008_LSB_TAIL_EN
    LSB        = 3'd5,
`endif
    ZERO       = 3'd6
  } state_t;

  logic       r_clk_s1, r_clk_s2, r_clk_s3;
  logic       r_cs_s1, r_cs_s2, r_cs_s3;
  logic       r_din_s1, r_din_s2;
  logic [1:0] r_live;
  logic       r_armed;

  state_t     r_state, w_state_next;
  logic [3:0] r_cmd, w_cmd_next;
  logic [3:0] r_bitcnt, w_bitcnt_next;
  logic [9:0] r_result, w_result_next;
  logic       r_dout, w_dout_next;
  logic       r_dout_oe, w_oe_next;
  logic [2:0] r_last_ch, w_last_ch_next;
  logic       r_last_sgl, w_last_sgl_next;
  logic       r_frame_done, w_done_next;
  logic       r_frame_err, w_err_next;

  logic       w_rise, w_fall, w_cs_rise, w_cs_fall;
  logic [3:0] w_cmd_full;
  logic [2:0] w_p, w_m;
  logic [9:0] w_result;
  logic [9:0] w_ch [8];

  // r_live/r_armed stop a cs held low through reset from looking like a fresh falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_s3 <= 1'b0;
      r_cs_s1  <= 1'b1;
      r_cs_s2  <= 1'b1;
      r_cs_s3  <= 1'b1;
      r_din_s1 <= 1'b0;
      r_din_s2 <= 1'b0;
      r_live   <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_clk_s1 <= ad_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_cs_s1  <= cs;
      r_cs_s2  <= r_cs_s1;
      r_cs_s3  <= r_cs_s2;
      r_din_s1 <= din;
      r_din_s2 <= r_din_s1;
      r_live   <= {r_live[0], 1'b1};
      if (r_live[1] && r_cs_s2) r_armed <= 1'b1;
    end
  end

  assign w_rise    =  r_clk_s2 & ~r_clk_s3;
  assign w_fall    = ~r_clk_s2 &  r_clk_s3;
  assign w_cs_rise =  r_cs_s2  & ~r_cs_s3;
  assign w_cs_fall = ~r_cs_s2  &  r_cs_s3;

  for (genvar gi = 0; gi < 8; gi++) begin : g_ch
    assign w_ch[gi] = ch_data[gi*10 +: 10];
  end

  // {SGL,D2,D1,D0} as it stands on the edge that samples D0
  assign w_cmd_full = {r_cmd[2:0], r_din_s2};
  assign w_p        = w_cmd_full[2:0];
  assign w_m        = {w_cmd_full[2:1], ~w_cmd_full[0]};
  assign w_result   = w_cmd_full[3] ? w_ch[w_p] :
                      (w_ch[w_p] > w_ch[w_m]) ? (w_ch[w_p] - w_ch[w_m]) : 10'd0;

  always_comb begin
    w_state_next    = r_state;
    w_cmd_next      = r_cmd;
    w_bitcnt_next   = r_bitcnt;
    w_result_next   = r_result;
    w_dout_next     = r_dout;
    w_oe_next       = r_dout_oe;
    w_last_ch_next  = r_last_ch;
    w_last_sgl_next = r_last_sgl;
    w_done_next     = 1'b0;
    w_err_next      = 1'b0;
    if (w_cs_rise) begin
      w_state_next = IDLE;
      w_dout_next  = 1'b0;
      w_oe_next    = 1'b0;
      if (r_state == CMD || r_state == NULLB || r_state == MSB) w_err_next = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: if (w_cs_fall && r_armed) w_state_next = WAIT_START;
        WAIT_START: if (w_rise && !r_cs_s2 && r_din_s2) begin
          w_state_next  = CMD;
          w_bitcnt_next = 4'd0;
        end
        CMD: if (w_rise && !r_cs_s2) begin
          w_cmd_next = w_cmd_full;
          if (r_bitcnt == 4'd3) begin
            w_state_next  = NULLB;
            w_result_next = w_result;
          end else begin
            w_bitcnt_next = r_bitcnt + 4'd1;
          end
        end
        NULLB: if (w_fall) begin
          w_dout_next   = 1'b0;
          w_oe_next     = 1'b1;
          w_state_next  = MSB;
          w_bitcnt_next = 4'd9;
        end
        MSB: if (w_fall) begin
          w_dout_next = r_result[r_bitcnt];
          w_oe_next   = 1'b1;
          if (r_bitcnt == 4'd0) begin
            w_done_next     = 1'b1;
            w_last_ch_next  = r_cmd[2:0];
            w_last_sgl_next = r_cmd[3];
`ifdef MCP3008_LSB_TAIL_EN
            w_state_next    = LSB;
            w_bitcnt_next   = 4'd1;
`else
            w_state_next    = ZERO;
`endif
          end else begin
            w_bitcnt_next = r_bitcnt - 4'd1;
          end
        end
`ifdef MCP3008_LSB_TAIL_EN
        LSB: if (w_fall) begin
          w_dout_next = r_result[r_bitcnt];
          w_oe_next   = 1'b1;
          if (r_bitcnt == 4'd9) w_state_next = ZERO;
          else                  w_bitcnt_next = r_bitcnt + 4'd1;
        end
`endif
        ZERO: if (w_fall) begin
          w_dout_next = 1'b0;
          w_oe_next   = 1'b1;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cmd        <= 4'd0;
      r_bitcnt     <= 4'd0;
      r_result     <= 10'd0;
      r_dout       <= 1'b0;
      r_dout_oe    <= 1'b0;
      r_last_ch    <= 3'd0;
      r_last_sgl   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cmd        <= w_cmd_next;
      r_bitcnt     <= w_bitcnt_next;
      r_result     <= w_result_next;
      r_dout       <= w_dout_next;
      r_dout_oe    <= w_oe_next;
      r_last_ch    <= w_last_ch_next;
      r_last_sgl   <= w_last_sgl_next;
      r_frame_done <= w_done_next;
      r_frame_err  <= w_err_next;
    end
  end

  assign dout       = r_dout;
  assign dout_oe    = r_dout_oe;
  assign last_ch    = r_last_ch;
  assign last_sgl   = r_last_sgl;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Bench for mcp3008_responder: drives SPI frames and scoreboards the serial reply.
module tb_mcp3008_responder;
  logic        clk = 1'b0;
  logic        rst_n, ad_clk, cs, din;
  logic [79:0] ch_data;
  logic        dout, dout_oe, last_sgl, frame_done, frame_err;
  logic [2:0]  last_ch;

  int n_vec = 0, n_err = 0;
  int done_cnt = 0, ferr_cnt = 0;
  logic q_exp[$];

  mcp3008_responder dut (
    .clk(clk), .rst_n(rst_n), .ad_clk(ad_clk), .cs(cs), .din(din), .ch_data(ch_data),
    .dout(dout), .dout_oe(dout_oe), .last_ch(last_ch), .last_sgl(last_sgl),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  ferr_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reply bit o positions after the null bit's falling edge (o=0 is the null bit)
  function automatic logic exp_bit(input int o, input logic [9:0] res);
    if (o == 0) return 1'b0;
    if (o <= 10) return res[10-o];
`ifdef MCP3008_LSB_TAIL_EN
    if (o <= 19) return res[o-10];
`endif
    return 1'b0;
  endfunction

  function automatic logic [9:0] model(input logic [79:0] c, input logic sgl, input logic [2:0] d);
    int p, m;
    p = int'(c[int'(d)*10 +: 10]);
    m = int'(c[int'(d ^ 3'd1)*10 +: 10]);
    if (sgl) return 10'(p);
    if (p > m) return 10'(p - m);
    return 10'd0;
  endfunction

  task automatic set_ch(input int n, input logic [9:0] v);
    ch_data[n*10 +: 10] = v;
  endtask

  // lz leading zeros, start bit, 4 command bits, then clocks up to n_falls falling edges
  task automatic run_frame(input int lz, input logic sgl, input logic [2:0] d,
                           input logic [9:0] res, input int n_falls, input bit raise_cs);
    logic [79:0] saved;
    logic [4:0]  cmd;
    int          base;
    cmd  = {1'b1, sgl, d};
    base = lz + 4;
    q_exp.delete();
    for (int j = base; j < n_falls; j++) q_exp.push_back(exp_bit(j - base, res));
    saved = ch_data;
    cs = 1'b0;
    tick(10);
    for (int k = 0; k < n_falls; k++) begin
      if (k < lz)          din = 1'b0;
      else if (k <= lz+4)  din = cmd[4-(k-lz)];
      else                 din = 1'b0;
      tick(10);
      ad_clk = 1'b1;
      tick(10);
      ad_clk = 1'b0;
      tick(3);
      if (k >= base) begin
        n_vec++;
        if (q_exp.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_empty at fall %0d", k);
        end else begin
          logic e;
          e = q_exp.pop_front();
          if (dout !== e || dout_oe !== 1'b1) begin
            n_err++;
            $display("FAIL dout_bit fall %0d (ch %0d sgl %b): got dout=%b oe=%b, expected dout=%b oe=1",
                     k, d, sgl, dout, dout_oe, e);
          end
        end
        if (k == base) ch_data = ~ch_data;
      end
    end
    ch_data = saved;
    if (raise_cs) begin
      cs  = 1'b1;
      din = 1'b0;
      tick(12);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cs = 1'b1; ad_clk = 1'b0; din = 1'b0;
    ch_data = '0;
    tick(5);
    n_vec++;
    if ({dout, dout_oe, last_ch, last_sgl, frame_done, frame_err} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_hold: got dout=%b oe=%b last_ch=%0d sgl=%b done=%b err=%b, expected all 0",
               dout, dout_oe, last_ch, last_sgl, frame_done, frame_err);
    end
    rst_n = 1'b1;
    tick(5);
    n_vec++;
    if ({dout, dout_oe, last_ch, last_sgl, frame_done, frame_err} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_release: got dout=%b oe=%b last_ch=%0d sgl=%b done=%b err=%b, expected all 0",
               dout, dout_oe, last_ch, last_sgl, frame_done, frame_err);
    end
  endtask

  task automatic check_end(input string name, input int d0, input int e0, input int exp_done,
                           input int exp_ferr, input logic [2:0] ech, input logic esgl);
    n_vec++;
    if (done_cnt - d0 != exp_done || ferr_cnt - e0 != exp_ferr || last_ch !== ech || last_sgl !== esgl) begin
      n_err++;
      $display("FAIL %s end: got done=%0d err=%0d last_ch=%0d last_sgl=%b, expected done=%0d err=%0d last_ch=%0d last_sgl=%b",
               name, done_cnt - d0, ferr_cnt - e0, last_ch, last_sgl, exp_done, exp_ferr, ech, esgl);
    end
  endtask

  task automatic test_sgl_ch3;
    int d0, e0;
    ch_data = {$urandom, $urandom, $urandom};
    set_ch(3, 10'h2A5);
    d0 = done_cnt; e0 = ferr_cnt;
    run_frame(0, 1'b1, 3'd3, 10'h2A5, 26, 1'b1);
    check_end("sgl_ch3", d0, e0, 1, 0, 3'd3, 1'b1);
  endtask

  task automatic test_diff;
    int d0, e0;
    set_ch(4, 10'd600);
    set_ch(5, 10'd200);
    d0 = done_cnt; e0 = ferr_cnt;
    run_frame(0, 1'b0, 3'd4, 10'd400, 16, 1'b1);
    check_end("diff_4_5", d0, e0, 1, 0, 3'd4, 1'b0);
    d0 = done_cnt; e0 = ferr_cnt;
    run_frame(0, 1'b0, 3'd5, 10'd0, 16, 1'b1);
    check_end("diff_5_4_clamp", d0, e0, 1, 0, 3'd5, 1'b0);
  endtask

  task automatic test_leading_zeros;
    int d0, e0;
    set_ch(7, 10'h3FF);
    d0 = done_cnt; e0 = ferr_cnt;
    run_frame(3, 1'b1, 3'd7, 10'h3FF, 19, 1'b1);
    check_end("lead_zeros_ch7", d0, e0, 1, 0, 3'd7, 1'b1);
  endtask

  task automatic test_cs_abort;
    int d0, e0;
    set_ch(2, 10'h15A);
    d0 = done_cnt; e0 = ferr_cnt;
    run_frame(0, 1'b1, 3'd2, 10'h15A, 10, 1'b0);
    cs = 1'b1;
    tick(3);
    n_vec++;
    if (dout_oe !== 1'b0 || dout !== 1'b0) begin
      n_err++;
      $display("FAIL cs_abort_release: got dout=%b oe=%b 3 clk after cs rise, expected 0/0", dout, dout_oe);
    end
    tick(10);
    check_end("cs_abort", d0, e0, 0, 1, 3'd7, 1'b1);
  endtask

  task automatic test_tail_ch0;
    int d0, e0;
    set_ch(0, 10'h001);
    d0 = done_cnt; e0 = ferr_cnt;
    run_frame(0, 1'b1, 3'd0, 10'h001, 31, 1'b1);
    check_end("tail_ch0", d0, e0, 1, 0, 3'd0, 1'b1);
  endtask

  task automatic test_reset_midframe;
    int d0, e0;
    set_ch(3, 10'h2A5);
    set_ch(6, 10'h0C3);
    d0 = done_cnt; e0 = ferr_cnt;
    run_frame(0, 1'b1, 3'd3, 10'h2A5, 8, 1'b0);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (dout !== 1'b0 || dout_oe !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midframe_outputs: got dout=%b oe=%b, expected 0/0", dout, dout_oe);
    end
    tick(3);
    rst_n = 1'b1;
    tick(3);
    cs = 1'b1;
    tick(10);
    check_end("reset_midframe", d0, e0, 0, 0, 3'd0, 1'b0);
    d0 = done_cnt; e0 = ferr_cnt;
    run_frame(0, 1'b1, 3'd6, 10'h0C3, 26, 1'b1);
    check_end("after_reset_frame", d0, e0, 1, 0, 3'd6, 1'b1);
  endtask

  task automatic test_back_to_back;
    int d0, e0, lz;
    logic       sgl;
    logic [2:0] d;
    for (int i = 0; i < 4; i++) begin
      ch_data = {$urandom, $urandom, $urandom};
      sgl = 1'($urandom_range(0, 1));
      d   = 3'($urandom_range(0, 7));
      lz  = int'($urandom_range(0, 2));
      d0 = done_cnt; e0 = ferr_cnt;
      run_frame(lz, sgl, d, model(ch_data, sgl, d), lz + 16, 1'b1);
      check_end("back_to_back", d0, e0, 1, 0, d, sgl);
    end
  endtask

  initial begin
    test_reset();
    test_sgl_ch3();
    test_diff();
    test_leading_zeros();
    test_cs_abort();
    test_tail_ch0();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mcp3008_responder.md
MCP3008_RESPONDER -- requirements
Module: mcp3008_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock, 50 MHz.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port ad_clk, input, 1 bit: SPI serial clock from the ADC master, asynchronous to clk.
REQ-004 SHALL have port cs, input, 1 bit: chip select, active-low, asynchronous.
REQ-005 SHALL have port din, input, 1 bit: command bits from the master.
REQ-006 SHALL have port ch_data, input, 80 bits: eight 10-bit channel values; channel n occupies bits [10n+9:10n].
REQ-007 SHALL have port dout, output, 1 bit: serial conversion data to the master.
REQ-008 SHALL have port dout_oe, output, 1 bit: 1 while dout is actively driven.
REQ-009 SHALL have port last_ch, output, 3 bits: D2..D0 of the last accepted command.
REQ-010 SHALL have port last_sgl, output, 1 bit: SGL/DIFF bit of the last accepted command.
REQ-011 SHALL have port frame_done, output, 1 bit: one-clk pulse when B0 is driven.
REQ-012 SHALL have port frame_err, output, 1 bit: one-clk pulse when cs rises before B0 is driven.

Function
REQ-013 SHALL synchronise ad_clk, cs and din through 2-flop synchronisers; ad_clk edges are detected from the synchronised copy; ad_clk high and low phases are each >= 8 clk.
REQ-014 SHALL sample din only on synchronised ad_clk rising edges while cs is low, and update dout only on synchronised falling edges.
REQ-015 SHALL implement the states IDLE, WAIT_START, CMD, NULLB, MSB, LSB and ZERO.
REQ-016 SHALL move from IDLE to WAIT_START on a cs falling edge.
REQ-017 SHALL, in WAIT_START, ignore rising edges that sample din=0; the first rising edge sampling din=1 is the start bit and moves to CMD.
REQ-018 SHALL, in CMD, sample 4 bits MSB first (SGL, D2, D1, D0); the edge that samples D0 moves to NULLB and snapshots the result value.
REQ-019 SHALL compute the result value as follows: SGL=1 gives ch_data[{D2,D1,D0}]; SGL=0 gives P={D2,D1,D0} and M={D2,D1,~D0}, result = (ch[P] > ch[M]) ? ch[P]-ch[M] : 0, 10-bit and never wrapping.
REQ-020 SHALL, in NULLB, drive dout=0 and dout_oe=1 on the next falling edge, then move to MSB.
REQ-021 SHALL, in MSB, drive B9..B0 on 10 successive falling edges; the edge driving B0 pulses frame_done and updates last_ch and last_sgl.
REQ-022 SHALL, after B0, go to LSB when the macro is defined, otherwise to ZERO.
REQ-023 SHALL, in ZERO, drive dout=0 with dout_oe=1 on every falling edge until cs rises.
REQ-024 SHALL, on a synchronised cs rising edge in any state, go to IDLE with dout=0 and dout_oe=0 within 1 clk; if the state was CMD, NULLB or MSB before B0, it pulses frame_err.
REQ-025 SHALL, when cs rising and falling occur on the same synchronised sample (too narrow to observe), remain in the current state.
REQ-026 SHALL change dout within 3 clk of the raw ad_clk falling edge.
REQ-027 SHALL keep ch_data changes after the snapshot from affecting the frame in progress.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state=IDLE, dout=0, dout_oe=0, last_ch=0, last_sgl=0, frame_done=0, frame_err=0 and all synchronisers to cs=1, ad_clk=0, din=0.
REQ-029 SHALL, when reset occurs mid-frame, abandon the frame silently with no frame_err; after rst_n releases, a new cs falling edge is required.

Configuration
REQ-030 SHALL, with MCP3008_LSB_TAIL_EN defined, drive B1..B9 (LSB-first tail, 9 bits) on the falling edges after B0, then enter ZERO.
REQ-031 SHALL, without MCP3008_LSB_TAIL_EN, enter ZERO directly after B0; LSB state logic is absent.

Verification
REQ-032 SHALL cover: ch3=10'h2A5, frame with cmd SGL=1,D=011 -> dout reads 0,1010100101 on falling edges; frame_done pulse; last_ch=3, last_sgl=1.
REQ-033 SHALL cover: ch4=600, ch5=200, SGL=0,D=100 -> result 400; with D=101 -> result 0 (clamped).
REQ-034 SHALL cover: cs raised after 5 of 10 data bits -> frame_err pulse, dout_oe=0 within 3 clk, last_ch unchanged.
REQ-035 SHALL cover: three leading zero bits before the start bit, ch7=10'h3FF, SGL=1,D=111 -> all ten data bits read 1.
REQ-036 SHALL cover: macro defined, ch0=10'h001, 30 clocks after the start bit -> MSB 0000000001, tail 000000000, then zeros; macro undefined -> zeros after B0.
REQ-037 SHALL cover: rst_n pulsed low during MSB -> dout=0, dout_oe=0 immediately, no frame_err; the next full frame is correct.
